// File: rtl/ipml_prefetch_fifo_v2_0.sv
// ipml_prefetch_fifo_v2_0: FWFT prefetch buffer in front of a fixed-latency synchronous-read RAM FIFO.
// Define IPML_PFF_RAM_OREG_EN when the SDPRAM output register is enabled (RAM latency 2 instead of 1).
module ipml_prefetch_fifo_v2_0 #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
`ifdef IPML_PFF_RAM_OREG_EN
  localparam int RAM_LAT = 2,
`else
  localparam int RAM_LAT = 1,
`endif
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              ram_empty,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  input  logic              rd_en,
  output logic [LVL_W-1:0]  pf_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  if (DEPTH < RAM_LAT + 1 || DEPTH > 16 || DATA_W < 1 || DATA_W > 1152) begin : g_bad_cfg
    $error("ipml_prefetch_fifo_v2_0: illegal DATA_W/DEPTH for this RAM latency");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic [RAM_LAT-1:0] tags;
  logic [LVL_W:0] credit;
  logic cap, pop;
  assign cap = tags[RAM_LAT-1] & ~flush;
  assign pop = rd_vld & rd_en & ~flush;
  // Buffered plus in-flight words; a read is only issued if its slot is guaranteed.
  always_comb begin
    credit = (LVL_W+1)'(count);
    for (int i = 0; i < RAM_LAT; i++) credit = credit + (LVL_W+1)'(tags[i]);
  end
  assign ram_rd_en = ~rd_rst & ~ram_empty & ~flush &
                     (credit - (LVL_W+1)'(pop) < (LVL_W+1)'(DEPTH));
  assign rd_vld = count != '0;
  assign rd_data = rd_vld ? mem[rd_ptr] : '0;
  assign pf_level = count;
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tags <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tags <= '0;
    end else begin
      tags <= RAM_LAT'({tags, ram_rd_en});
      if (cap) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= count + LVL_W'(cap) - LVL_W'(pop);
    end
  end
  always_ff @(posedge rd_clk) begin
    if (cap) mem[wr_ptr] <= ram_rd_data;
  end
endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0.sv
// tb_ipml_prefetch_fifo_v2_0: scoreboard bench with a queue-based RAM/consumer reference model.
// Define IPML_PFF_RAM_OREG_EN to exercise the latency-2 build with DEPTH=3.
module tb_ipml_prefetch_fifo_v2_0;
`ifdef IPML_PFF_RAM_OREG_EN
  localparam int LAT = 2;
  localparam int DEPTH = 3;
`else
  localparam int LAT = 1;
  localparam int DEPTH = 4;
`endif
  localparam int DW = 32;
  localparam int LW = $clog2(DEPTH + 1);
  typedef struct {
    logic [DW-1:0] d;
    int c;
  } ent_t;
  logic rd_clk = 0, rd_rst = 1, ram_empty = 1, flush = 0, rd_en = 0;
  logic ram_rd_en, rd_vld;
  logic [DW-1:0] ram_rd_data = '0, rd_data;
  logic [LW-1:0] pf_level;
  logic [DW-1:0] ram_q[$];
  ent_t exp_q[$];
  logic [DW-1:0] pa = '0, pb = '0;
  int checks = 0, failures = 0, cyc = 0, pops = 0;

  ipml_prefetch_fifo_v2_0 #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .ram_empty(ram_empty), .ram_rd_en(ram_rd_en),
    .ram_rd_data(ram_rd_data), .flush(flush), .rd_data(rd_data), .rd_vld(rd_vld),
    .rd_en(rd_en), .pf_level(pf_level)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, then account for RAM reads and flush.
  task automatic step(input bit en, input bit fl, input bit st);
    int lvl;
    bit pop_m;
    logic [DW-1:0] w;
    @(negedge rd_clk);
    cyc++;
    ram_rd_data = (LAT == 1) ? pa : pb;
    pb = pa;
    pa = $urandom;
    rd_en = en;
    flush = fl;
    ram_empty = st | (ram_q.size() == 0);
    #1;
    lvl = 0;
    foreach (exp_q[i]) if (exp_q[i].c + LAT + 1 <= cyc) lvl++;
    chk("pf_level", pf_level, lvl);
    chk("rd_vld", rd_vld, lvl != 0);
    pop_m = (lvl != 0) && en && !fl;
    chk("ram_rd_en", ram_rd_en, !ram_empty && !fl && (exp_q.size() - int'(pop_m) < DEPTH));
    if (fl) exp_q.delete();
    else if (ram_rd_en && ram_q.size() != 0) begin
      w = ram_q.pop_front();
      exp_q.push_back('{w, cyc});
      pa = w;
    end
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_en = 0;
    flush = 0;
    ram_empty = 1;
    #3;
    rd_rst = 1;
    #1;
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_pf_level", pf_level, 0);
    chk("rst_ram_rd_en", ram_rd_en, 0);
    exp_q.delete();
    @(negedge rd_clk);
    rd_rst = 0;
  endtask

  // Monitor: every real pop must deliver the oldest outstanding word.
  initial forever begin
    ent_t e;
    @(negedge rd_clk);
    #2;
    if (!rd_rst && !flush && rd_vld && rd_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_underflow: got %0h expected no word (cycle %0d)", rd_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e.d);
        pops++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nv, first, last, k, guard;
    do_reset();
    // Fill with consumer stalled
    for (int i = 0; i < 10; i++) ram_q.push_back(i);
    n = 0;
    repeat (12) begin
      step(0, 0, 0);
      n += int'(ram_rd_en);
    end
    chk("fill_pulses", n, DEPTH);
    chk("fill_level", pf_level, DEPTH);
    chk("fill_vld", rd_vld, 1);
    chk("fill_head", rd_data, 0);
    // Full-throughput drain
    do_reset();
    ram_q.delete();
    for (int i = 0; i < 10; i++) ram_q.push_back(i);
    nv = 0;
    first = -1;
    last = -1;
    repeat (20) begin
      step(1, 0, 0);
      if (rd_vld) begin
        nv++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    chk("stream_len", nv, 10);
    chk("stream_span", last - first + 1, 10);
    chk("drained_vld", rd_vld, 0);
    chk("drained_rd_en", ram_rd_en, 0);
    // Flush with DEPTH-1 buffered and one word in flight
    do_reset();
    ram_q.delete();
    for (int i = 0; i < 20; i++) ram_q.push_back(32'h200 + i);
    repeat (20) begin
      step(0, 0, 0);
      if (pf_level == LW'(DEPTH - 2)) break;
    end
    step(0, 1, 0);
    chk("preflush_level", pf_level, DEPTH - 1);
    step(0, 0, 0);
    chk("flush_level", pf_level, 0);
    chk("flush_vld", rd_vld, 0);
    chk("flush_resume", ram_rd_en, 1);
    k = 0;
    while (!rd_vld && k < 10) begin
      step(0, 0, 0);
      k++;
    end
    chk("refill_lat", k, LAT + 1);
    repeat (4) step(1, 0, 0);
    // Asynchronous reset mid-stream, then restart
    do_reset();
    ram_q.delete();
    for (int i = 0; i < 40; i++) ram_q.push_back(32'h300 + i);
    repeat (12) step(1, 0, 0);
    do_reset();
    repeat (40) step(1, 0, 0);
    chk("restart_drained", ram_q.size(), 0);
    // Random traffic: 1000 words, random consumer and RAM stalls
    do_reset();
    ram_q.delete();
    pops = 0;
    repeat (1000) ram_q.push_back($urandom);
    guard = 0;
    while ((ram_q.size() != 0 || exp_q.size() != 0) && guard < 20000) begin
      step(1'($urandom_range(0, 1)), 0, $urandom_range(0, 3) == 0);
      guard++;
    end
    step(0, 0, 0);
    chk("all_words", pops, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
